sc_scheduler: RTL and testbench

//  Sequences the M-wide PE array through the successive-cancellation (SC) tree schedule for one N-bit polar codeword.

---
 rtl/sc_pkg.sv | 31 +++
 rtl/sc_scheduler_if.sv | 38 +++
 rtl/sc_ctz.sv | 22 ++
 rtl/sc_scheduler.sv | 148 ++++++++++++++
 tb/tb_sc_scheduler.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared types and width/size helpers for the SC tree scheduler.
package sc_pkg;

    typedef enum logic {
        OP_F = 1'b0,
        OP_G = 1'b1
    } op_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OP,
        S_LEAF,
        S_DONE
    } state_e;

    // Width of the stage field: must hold stages 0..log_n.
    function automatic int unsigned sw_of(input int unsigned log_n);
        return $clog2(log_n + 1);
    endfunction

    // Width of the chunk field, at least one bit.
    function automatic int unsigned cw_of(input int unsigned log_n, input int unsigned log_m);
        return (log_n - 1 > log_m) ? (log_n - 1 - log_m) : 1;
    endfunction

    // Number of M-wide beats needed for one node operation at stage s.
    function automatic int unsigned chunks(input int unsigned s, input int unsigned log_m);
        return (s > log_m + 1) ? (32'd1 << (s - 1 - log_m)) : 32'd1;
    endfunction

endpackage

// File: rtl/sc_scheduler_if.sv
// Control, beat and leaf handshake bundle between the decoder control,
// the SC scheduler (master) and the LLR datapath / decision unit (slave).
import sc_pkg::*;

interface sc_scheduler_if #(
    parameter int unsigned LOG_N = 10,
    parameter int unsigned LOG_M = 9
);
    localparam int unsigned SW = sw_of(LOG_N);
    localparam int unsigned CW = cw_of(LOG_N, LOG_M);

    logic             start;
    logic             abort;
    logic             busy;
    logic             done;
    logic             op_valid;
    logic             op_ready;
    op_type_e         op_type;
    logic [SW-1:0]    op_stage;
    logic [CW-1:0]    op_chunk;
    logic             op_last;
    logic             leaf_valid;
    logic [LOG_N-1:0] leaf_idx;
    logic             leaf_ack;
    logic [31:0]      op_cycles;

    modport master (
        input  start, abort, op_ready, leaf_ack,
        output busy, done, op_valid, op_type, op_stage, op_chunk, op_last,
               leaf_valid, leaf_idx, op_cycles
    );

    modport slave (
        output start, abort, op_ready, leaf_ack,
        input  busy, done, op_valid, op_type, op_stage, op_chunk, op_last,
               leaf_valid, leaf_idx, op_cycles
    );
endinterface

// File: rtl/sc_ctz.sv
// Combinational trailing-zero count of a leaf index; an all-zero input yields 0.
module sc_ctz
    import sc_pkg::*;
#(
    parameter int unsigned LOG_N = 10,
    parameter int unsigned SW    = sw_of(LOG_N)
) (
    input  logic [LOG_N-1:0] value,
    output logic [SW-1:0]    count
);

    // Scan from the MSB down so the lowest set bit is the last one written.
    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < LOG_N; k++) begin
            if (value[LOG_N-1-k]) begin
                count = SW'(LOG_N - 1 - k);
            end
        end
    end

endmodule

// File: rtl/sc_scheduler.sv
// SC tree schedule sequencer: walks leaves 0..N-1, emitting F/G beats per node
// (stage, chunk) and a leaf request per leaf. Optional active-cycle counter is
// built only when PERF_CNT_EN is defined.
module sc_scheduler
    import sc_pkg::*;
#(
    parameter int unsigned LOG_N = 10,
    parameter int unsigned LOG_M = 9
) (
    input logic          clk,
    input logic          rst,
    sc_scheduler_if.master bus
);
    localparam int unsigned      SW        = sw_of(LOG_N);
    localparam int unsigned      CW        = cw_of(LOG_N, LOG_M);
    localparam logic [LOG_N-1:0] LAST_LEAF = '1;
    localparam logic [SW-1:0]    TOP_STAGE = SW'(LOG_N);
    localparam logic [SW-1:0]    BOT_STAGE = SW'(1);

    state_e           state, state_n;
    logic [LOG_N-1:0] leaf, leaf_n;
    logic [SW-1:0]    stage, stage_n;
    logic [CW-1:0]    chunk, chunk_n;
    op_type_e         otype, otype_n;

    logic [LOG_N-1:0] leaf_inc;
    logic [SW-1:0]    leaf_tz;
    logic             last;

    assign leaf_inc = leaf + 1'b1;
    assign last     = (chunk == CW'(chunks(32'(stage), LOG_M) - 32'd1));

    sc_ctz #(.LOG_N(LOG_N), .SW(SW)) u_ctz (
        .value (leaf_inc),
        .count (leaf_tz)
    );

    // State and schedule counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            leaf  <= '0;
            stage <= '0;
            chunk <= '0;
            otype <= OP_F;
        end else begin
            state <= state_n;
            leaf  <= leaf_n;
            stage <= stage_n;
            chunk <= chunk_n;
            otype <= otype_n;
        end
    end

    // Next-state: beats advance only on transfer; leaf i>0 starts with G at ctz(i)+1.
    always_comb begin
        state_n = state;
        leaf_n  = leaf;
        stage_n = stage;
        chunk_n = chunk;
        otype_n = otype;
        if (bus.abort) begin
            state_n = S_IDLE;
            leaf_n  = '0;
            stage_n = '0;
            chunk_n = '0;
            otype_n = OP_F;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state_n = S_OP;
                        leaf_n  = '0;
                        stage_n = TOP_STAGE;
                        chunk_n = '0;
                        otype_n = OP_F;
                    end
                end
                S_OP: begin
                    if (bus.op_ready) begin
                        if (!last) begin
                            chunk_n = chunk + 1'b1;
                        end else begin
                            chunk_n = '0;
                            otype_n = OP_F;
                            if (stage == BOT_STAGE) begin
                                state_n = S_LEAF;
                            end else begin
                                stage_n = stage - 1'b1;
                            end
                        end
                    end
                end
                S_LEAF: begin
                    if (bus.leaf_ack) begin
                        if (leaf == LAST_LEAF) begin
                            state_n = S_DONE;
                        end else begin
                            state_n = S_OP;
                            leaf_n  = leaf_inc;
                            stage_n = leaf_tz + 1'b1;
                            chunk_n = '0;
                            otype_n = OP_G;
                        end
                    end
                end
                S_DONE: begin
                    state_n = S_IDLE;
                    leaf_n  = '0;
                    stage_n = '0;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != S_IDLE);
    assign bus.done       = (state == S_DONE);
    assign bus.op_valid   = (state == S_OP);
    assign bus.op_type    = bus.op_valid ? otype : OP_F;
    assign bus.op_stage   = bus.op_valid ? stage : '0;
    assign bus.op_chunk   = bus.op_valid ? chunk : '0;
    assign bus.op_last    = bus.op_valid & last;
    assign bus.leaf_valid = (state == S_LEAF);
    assign bus.leaf_idx   = bus.leaf_valid ? leaf : '0;

`ifdef PERF_CNT_EN
    logic [31:0] cycles;

    // Busy-cycle counter: cleared on accepted start or abort, held once idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles <= '0;
        end else if (bus.abort) begin
            cycles <= '0;
        end else if (state == S_IDLE && bus.start) begin
            cycles <= '0;
        end else if (state != S_IDLE) begin
            cycles <= cycles + 32'd1;
        end
    end

    assign bus.op_cycles = cycles;
`else
    assign bus.op_cycles = '0;
`endif

endmodule

// File: tb/tb_sc_scheduler.sv
// Randomised self-checking bench for sc_scheduler (LOG_N=3, LOG_M=1).
module tb_sc_scheduler;
    import sc_pkg::*;

    localparam int LOG_N = 3;
    localparam int LOG_M = 1;
    localparam int N     = 1 << LOG_N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sc_scheduler_if #(.LOG_N(LOG_N), .LOG_M(LOG_M)) bus ();

    sc_scheduler #(.LOG_N(LOG_N), .LOG_M(LOG_M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit is_leaf;
        bit g;
        int stage;
        int chunk;
        bit last;
        int idx;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    failures = 0;
    bit    rnd_ready = 0, stray = 0, abort_arm = 0, ideal = 1, post_abort = 0;
    int    dly_leaf = -1, dly = 0;
    int    busy_cycles = 0, done_seen = 0, hold = 0, mon_hold = 0;

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Beats per node operation at stage s.
    function automatic int c_of(input int s);
        return (s - 1 > LOG_M) ? (1 << (s - 1 - LOG_M)) : 1;
    endfunction

    function automatic int pk(input item_t it);
        return it.g * 1000 + it.stage * 100 + it.chunk * 10 + it.last;
    endfunction

    function automatic int exp_cycles();
        int sum = N + 1;
        for (int s = 1; s <= LOG_N; s++) sum += (1 << (LOG_N - s + 1)) * c_of(s);
        return sum;
    endfunction

    task automatic push_op(input bit g, input int s);
        item_t it;
        for (int c = 0; c < c_of(s); c++) begin
            it = '{is_leaf: 0, g: g, stage: s, chunk: c, last: (c == c_of(s) - 1), idx: 0};
            exp_q.push_back(it);
        end
    endtask

    // Whole-codeword schedule from the leaf op-list rule.
    task automatic load_model();
        item_t lf;
        int    t;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (i == 0) begin
                for (int s = LOG_N; s >= 1; s--) push_op(1'b0, s);
            end else begin
                t = 0;
                while (((i >> t) & 1) == 0) t++;
                push_op(1'b1, t + 1);
                for (int s = t; s >= 1; s--) push_op(1'b0, s);
            end
            lf = '{is_leaf: 1, g: 0, stage: 0, chunk: 0, last: 0, idx: i};
            exp_q.push_back(lf);
        end
    endtask

    // Input drivers, all updated 1 time unit after the active edge.
    initial begin
        bus.op_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.op_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    initial begin
        bus.leaf_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.leaf_valid) begin
                bus.leaf_ack = (hold >= ((int'(bus.leaf_idx) == dly_leaf) ? dly : 0));
                hold++;
            end else begin
                hold = 0;
                bus.leaf_ack = stray ? 1'($urandom % 2) : 1'b0;
            end
        end
    end

    initial begin
        bus.abort = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (abort_arm && bus.op_valid && bus.op_type == OP_G &&
                int'(bus.op_stage) == 3 && int'(bus.op_chunk) == 1) begin
                bus.abort = 1'b1;
                abort_arm = 0;
            end else begin
                bus.abort = 1'b0;
            end
        end
    end

    // Compare process: every beat/leaf cycle against the head of the model queue.
    always @(negedge clk) begin
        if (!rst) begin
            int   req;
            item_t act;
            if (post_abort) begin
                post_abort = 0;
                check_eq("idle_after_abort",
                         {bus.busy, bus.op_valid, bus.leaf_valid, bus.done}, 0);
            end
            if (bus.busy) busy_cycles++;
            if (bus.op_valid) begin
                check_eq("op_and_leaf_overlap", bus.leaf_valid, 0);
                act = '{is_leaf: 0, g: bus.op_type, stage: int'(bus.op_stage),
                        chunk: int'(bus.op_chunk), last: bus.op_last, idx: 0};
                req = (exp_q.size() > 0 && !exp_q[0].is_leaf) ? pk(exp_q[0]) : -1;
                check_eq("beat", pk(act), req);
                if (bus.op_ready && !bus.abort && req >= 0) void'(exp_q.pop_front());
            end
            if (bus.leaf_valid) begin
                mon_hold++;
                req = (exp_q.size() > 0 && exp_q[0].is_leaf) ? exp_q[0].idx : -1;
                check_eq("leaf_idx", bus.leaf_idx, req);
                if (bus.leaf_ack && !bus.abort) begin
                    check_eq("leaf_hold", mon_hold, (req == dly_leaf) ? dly + 1 : 1);
                    mon_hold = 0;
                    if (req >= 0) void'(exp_q.pop_front());
                end
            end
            if (bus.done) begin
                done_seen++;
                check_eq("done_queue_empty", exp_q.size(), 0);
            end
            if (bus.abort) begin
                exp_q.delete();
                post_abort = 1;
                mon_hold = 0;
            end
        end
    end

    task automatic run(input bit do_abort);
        int  dbefore;
        bit  fin;
        int  n;
        dbefore = done_seen;
        load_model();
        busy_cycles = 0;
        abort_arm = do_abort;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check_eq("first_beat", {bus.busy, bus.op_valid}, 2'b11);
        fin = 0;
        for (n = 0; n < 2000 && !fin; n++) begin
            @(posedge clk); #1;
            bus.start = (stray && bus.busy && !bus.done) ? 1'($urandom % 2) : 1'b0;
            fin = bus.done || (do_abort && !abort_arm && !bus.busy);
        end
        bus.start = 1'b0;
        if (!fin) check_eq("run_timeout", n, 0);
        if (do_abort) begin
            repeat (2) @(posedge clk);
            #1;
            check_eq("abort_no_done", done_seen - dbefore, 0);
            check_eq("abort_busy", bus.busy, 0);
            return;
        end
        @(posedge clk); #1;
        check_eq("done_pulse", {bus.busy, bus.done}, 0);
        check_eq("done_once", done_seen - dbefore, 1);
        if (ideal) check_eq("busy_cycles", busy_cycles, exp_cycles());
        repeat (2) @(posedge clk);
        #1;
`ifdef PERF_CNT_EN
        check_eq("op_cycles", bus.op_cycles, busy_cycles);
`else
        check_eq("op_cycles", bus.op_cycles, 0);
`endif
    endtask

    initial begin
        int nb;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs",
                 {bus.busy, bus.done, bus.op_valid, bus.op_type, bus.op_stage, bus.op_chunk,
                  bus.op_last, bus.leaf_valid, bus.leaf_idx, bus.op_cycles}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model against hand-derived schedule points.
        load_model();
        nb = 0;
        foreach (exp_q[k]) if (!exp_q[k].is_leaf) nb++;
        check_eq("model_beats", nb, 16);
        check_eq("model_items", exp_q.size(), 24);
        check_eq("model_first", pk(exp_q[0]), 300);
        check_eq("model_f3c1", pk(exp_q[1]), 311);
        check_eq("model_leaf0", exp_q[4].idx + 100 * exp_q[4].is_leaf, 100);
        check_eq("model_g3c0", pk(exp_q[12]), 1300);
        check_eq("model_g3c1", pk(exp_q[13]), 1311);
        check_eq("model_leaf4", exp_q[16].idx + 100 * exp_q[16].is_leaf, 104);
        check_eq("model_cycles", exp_cycles(), 25);

        ideal = 1; run(0);                         // ideal handshakes
        ideal = 0; rnd_ready = 1; run(0);          // random back-pressure
        rnd_ready = 0;
        dly_leaf = 3; dly = 5; run(0);             // slow decision on leaf 3
        dly_leaf = -1; dly = 0;
        run(1);                                    // abort during G3c1
        ideal = 1; run(0);                         // clean restart
        stray = 1; run(0);                         // start while busy, stray acks
        stray = 0;
        rnd_ready = 1; ideal = 0; stray = 1; run(0);
        rnd_ready = 0; stray = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
